// File: rtl/data_memory_responder.sv
// Block-memory slave for the data cache refill/write-back interface.
// Serves one 128-bit block access at a time behind a fixed MEM_BUSY_WAIT latency.
module data_memory_responder #(
  parameter int ADDR_WIDTH = 28,
  parameter int DEPTH      = 256,
  parameter int LATENCY    = 4
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  MEM_READ,
  input  logic                  MEM_WRITE,
  input  logic [ADDR_WIDTH-1:0] MEM_ADDRESS,
  input  logic [127:0]          MEM_WRITE_DATA,
  output logic [127:0]          MEM_READ_DATA,
  output logic                  MEM_BUSY_WAIT,
  output logic                  MEM_ERROR
);

  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                state, state_n;
  logic [CNT_W-1:0]      cnt;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic                  lat_write;
  logic [127:0]          lat_data;
  logic [127:0]          mem [DEPTH];

  logic accept, access, in_range, req_in_range;
  logic [IDX_W-1:0] idx;

  // Range checks are done one bit wider so DEPTH == 2^ADDR_WIDTH still fits.
  assign req_in_range = {1'b0, MEM_ADDRESS} < (ADDR_WIDTH+1)'(DEPTH);
  assign in_range     = {1'b0, lat_addr} < (ADDR_WIDTH+1)'(DEPTH);
  assign idx          = lat_addr[IDX_W-1:0];

  always_ff @(posedge CLK) begin
    if (!RESET) state <= IDLE;
    else        state <= state_n;
  end

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    state_n = state;
    accept  = 1'b0;
    access  = 1'b0;
    case (state)
      IDLE: if (MEM_READ || MEM_WRITE) begin
        accept  = 1'b1;
        state_n = BUSY;
      end
      BUSY: if (cnt == '0) begin
        access  = 1'b1;
        state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      cnt           <= '0;
      MEM_BUSY_WAIT <= 1'b0;
      MEM_READ_DATA <= '0;
      MEM_ERROR     <= 1'b0;
    end else begin
      if (accept) begin
        cnt           <= CNT_W'(LATENCY - 1);
        MEM_BUSY_WAIT <= 1'b1;
        if ((MEM_READ && MEM_WRITE) || !req_in_range) MEM_ERROR <= 1'b1;
      end else if (state == BUSY && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (access) begin
        MEM_BUSY_WAIT <= 1'b0;
        if (!lat_write) MEM_READ_DATA <= in_range ? mem[idx] : '0;
      end
    end
  end

  // Request capture; a simultaneous read+write is taken as a write.
  always_ff @(posedge CLK) begin
    if (accept) begin
      lat_addr  <= MEM_ADDRESS;
      lat_write <= MEM_WRITE;
      lat_data  <= MEM_WRITE_DATA;
    end
  end

  // NOTE: the block array is deliberately not reset; only the commit is gated by RESET so an aborted write never lands.
  always_ff @(posedge CLK) begin
    if (RESET && access && lat_write && in_range) mem[idx] <= lat_data;
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// Bench for data_memory_responder: a LATENCY=4 and a LATENCY=1 instance checked
// every cycle against a transaction-level model plus directed literal expectations.
module tb_data_memory_responder;

  localparam int AW    = 28;
  localparam int DEPTH = 256;

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  logic          rd4, wr4, busy4, err4, rd1, wr1, busy1, err1;
  logic [AW-1:0] addr4, addr1;
  logic [127:0]  wd4, wd1, rdata4, rdata1;

  data_memory_responder #(.ADDR_WIDTH(AW), .DEPTH(DEPTH), .LATENCY(4)) dut4 (
    .CLK(CLK), .RESET(RESET), .MEM_READ(rd4), .MEM_WRITE(wr4), .MEM_ADDRESS(addr4),
    .MEM_WRITE_DATA(wd4), .MEM_READ_DATA(rdata4), .MEM_BUSY_WAIT(busy4), .MEM_ERROR(err4));

  data_memory_responder #(.ADDR_WIDTH(AW), .DEPTH(DEPTH), .LATENCY(1)) dut1 (
    .CLK(CLK), .RESET(RESET), .MEM_READ(rd1), .MEM_WRITE(wr1), .MEM_ADDRESS(addr1),
    .MEM_WRITE_DATA(wd1), .MEM_READ_DATA(rdata1), .MEM_BUSY_WAIT(busy1), .MEM_ERROR(err1));

  int n_checks = 0;
  int n_fail   = 0;
  bit checking = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Transaction-level model: an access occupies LATENCY busy cycles, then one
  // cool-down cycle, and the block array is a plain array with known-flags.
  int           busy_left [2];
  int           cool      [2];
  logic         m_busy    [2];
  logic         m_err     [2];
  logic         m_rknown  [2];
  logic         m_wr      [2];
  logic [127:0] m_rdata   [2];
  logic [127:0] m_d       [2];
  logic [AW-1:0] m_a      [2];
  logic [127:0] m_mem     [2][DEPTH];
  bit           m_valid   [2][DEPTH];

  task automatic model_step(input int u, input int lat, input logic rst, input logic r,
                            input logic w, input logic [AW-1:0] a, input logic [127:0] d);
    if (!rst) begin
      busy_left[u] = 0; cool[u] = 0; m_busy[u] = 0; m_err[u] = 0;
      m_rdata[u] = '0; m_rknown[u] = 1;
    end else if (busy_left[u] > 0) begin
      busy_left[u]--;
      if (busy_left[u] == 0) begin
        m_busy[u] = 0;
        cool[u]   = 1;
        if (m_wr[u]) begin
          if (m_a[u] < DEPTH) begin
            m_mem[u][int'(m_a[u])]   = m_d[u];
            m_valid[u][int'(m_a[u])] = 1;
          end
        end else if (m_a[u] >= DEPTH) begin
          m_rdata[u] = '0; m_rknown[u] = 1;
        end else begin
          m_rdata[u]  = m_mem[u][int'(m_a[u])];
          m_rknown[u] = m_valid[u][int'(m_a[u])];
        end
      end
    end else if (cool[u] > 0) begin
      cool[u]--;
    end else if (r || w) begin
      m_wr[u] = w; m_a[u] = a; m_d[u] = d;
      busy_left[u] = lat;
      m_busy[u]    = 1;
      if ((r && w) || a >= DEPTH) m_err[u] = 1;
    end
  endtask

  always @(posedge CLK) begin
    model_step(0, 4, RESET, rd4, wr4, addr4, wd4);
    model_step(1, 1, RESET, rd1, wr1, addr1, wd1);
  end

  task automatic cmp_unit(input int u, input logic busy, input logic [127:0] rdata, input logic err);
    check($sformatf("u%0d_busy", u), 128'(busy), 128'(m_busy[u]));
    check($sformatf("u%0d_error", u), 128'(err), 128'(m_err[u]));
    if (m_rknown[u]) check($sformatf("u%0d_rdata", u), rdata, m_rdata[u]);
  endtask

  always @(negedge CLK) begin
    if (checking) begin
      cmp_unit(0, busy4, rdata4, err4);
      cmp_unit(1, busy1, rdata1, err1);
    end
  end

  // One complete handshake; optionally moves the address mid-access. Drops the
  // request in the first not-busy cycle, which is the responder's DONE cycle.
  task automatic access(input int u, input logic r, input logic w, input logic [AW-1:0] a,
                        input logic [127:0] d, input int chg_at, input logic [AW-1:0] chg_a,
                        output int nbusy);
    int t;
    logic b;
    nbusy = 0;
    t = 0;
    @(negedge CLK);
    if (u == 0) begin rd4 = r; wr4 = w; addr4 = a; wd4 = d; end
    else        begin rd1 = r; wr1 = w; addr1 = a; wd1 = d; end
    do begin
      @(negedge CLK);
      t++;
      b = (u == 0) ? busy4 : busy1;
      if (b) nbusy++;
      if (t == chg_at && u == 0) addr4 = chg_a;
    end while ((b || nbusy == 0) && t < 20);
    if (u == 0) begin rd4 = 0; wr4 = 0; end
    else        begin rd1 = 0; wr1 = 0; end
    if (t >= 20) begin
      n_checks++;
      n_fail++;
      $display("FAIL access_timeout: unit %0d busy never completed within 20 cycles", u);
    end
  endtask

  localparam logic [127:0] BLK_A = 128'hDDDD_DDDD_CCCC_CCCC_BBBB_BBBB_AAAA_AAAA;
  localparam logic [127:0] BLK_B = 128'h0606_0606_1111_2222_3333_4444_5555_6666;
  localparam logic [127:0] BLK_C = 128'h2020_2020_CAFE_F00D_1234_5678_9ABC_DEF0;
  localparam logic [127:0] BLK_E = 128'h2C2C_2C2C_0BAD_BEEF_FEED_FACE_0000_0001;
  localparam logic [127:0] BLK_F = 128'hFFFF_0000_FFFF_0000_FFFF_0000_FFFF_0000;
  localparam logic [127:0] BLK_X = 128'hDEAD_DEAD_DEAD_DEAD_DEAD_DEAD_DEAD_DEAD;
  localparam logic [127:0] BLK_3 = 128'h0000_0003_0000_0002_0000_0001_0000_0000;

  initial begin
    int nb;
    RESET = 0;
    rd4 = 0; wr4 = 0; addr4 = '0; wd4 = '0;
    rd1 = 0; wr1 = 0; addr1 = '0; wd1 = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    checking = 1;
    check("reset_busy", 128'(busy4), 128'd0);
    check("reset_rdata", rdata4, 128'd0);
    check("reset_error", 128'(err4), 128'd0);
    RESET = 1;

    access(0, 0, 1, 28'h05, BLK_A, 0, '0, nb);
    check("wr05_busy_cycles", 128'(nb), 128'd4);
    access(0, 1, 0, 28'h05, '0, 0, '0, nb);
    check("rd05_busy_cycles", 128'(nb), 128'd4);
    check("rd05_data", rdata4, BLK_A);
    check("rd05_error", 128'(err4), 128'd0);

    access(0, 0, 1, 28'h06, BLK_B, 0, '0, nb);
    access(0, 1, 0, 28'h05, '0, 2, 28'h06, nb);
    check("rd05_addr_moved_data", rdata4, BLK_A);
    access(0, 1, 0, 28'h06, '0, 0, '0, nb);
    check("rd06_unchanged", rdata4, BLK_B);

    access(0, 0, 1, 28'h20, BLK_C, 0, '0, nb);
    access(0, 0, 1, 28'h2C, BLK_E, 0, '0, nb);

    access(0, 1, 1, 28'h10, 128'h1, 0, '0, nb);
    check("both_error", 128'(err4), 128'd1);
    check("both_rdata_kept", rdata4, BLK_B);
    access(0, 1, 0, 28'h10, '0, 0, '0, nb);
    check("rd10_data", rdata4, 128'h1);
    check("error_sticky", 128'(err4), 128'd1);

    access(0, 1, 0, 28'd300, '0, 0, '0, nb);
    check("rd300_busy_cycles", 128'(nb), 128'd4);
    check("rd300_data", rdata4, 128'h0);
    check("rd300_error", 128'(err4), 128'd1);
    access(0, 0, 1, 28'd300, BLK_F, 0, '0, nb);
    access(0, 1, 0, 28'h2C, '0, 0, '0, nb);
    check("rd2c_after_oob_write", rdata4, BLK_E);

    // Abort a write to 0x20 with reset in its second busy cycle.
    @(negedge CLK);
    wr4 = 1; addr4 = 28'h20; wd4 = BLK_X;
    @(negedge CLK);
    @(negedge CLK);
    RESET = 0;
    @(negedge CLK);
    RESET = 1; wr4 = 0;
    check("abort_busy", 128'(busy4), 128'd0);
    check("abort_rdata", rdata4, 128'd0);
    check("abort_error_cleared", 128'(err4), 128'd0);
    access(0, 1, 0, 28'h20, '0, 0, '0, nb);
    check("rd20_after_abort", rdata4, BLK_C);
    check("rd20_error", 128'(err4), 128'd0);

    // LATENCY=1: a continuously held read produces busy 1,0,0 repeating.
    access(1, 0, 1, 28'h03, BLK_3, 0, '0, nb);
    check("lat1_wr_busy_cycles", 128'(nb), 128'd1);
    @(negedge CLK);
    rd1 = 1; addr1 = 28'h03;
    for (int i = 0; i < 9; i++) begin
      @(negedge CLK);
      check($sformatf("lat1_pattern_%0d", i), 128'(busy1), 128'((i % 3) == 0));
    end
    rd1 = 0;
    check("lat1_rdata", rdata1, BLK_3);
    check("lat1_error", 128'(err1), 128'd0);

    repeat (3) @(negedge CLK);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/data_memory_responder.md
Name: data_memory_responder

Overview:
- Main-memory side of the cache-to-memory block interface: the slave that serves the data cache controller's MEM_READ/MEM_WRITE requests.
- Stores 128-bit blocks (4 x 32-bit words) and models a fixed access latency with MEM_BUSY_WAIT.
- Returns the refill block on MEM_READ_DATA and absorbs write-back blocks.
- Sits between the data cache controller and the system boundary in the data-memory module.

Parameters:
- ADDR_WIDTH, 28, block-address width (byte address [31:4]).
- DEPTH, 256, number of blocks stored; must be at most 2^ADDR_WIDTH.
- LATENCY, 4, cycles MEM_BUSY_WAIT stays high per access; must be at least 1.

Ports:
- CLK  input  1  system clock; all state changes on rising edge.
- RESET  input  1  synchronous, active-low reset (0 = reset).
- MEM_READ  input  1  block read request, held by the controller until MEM_BUSY_WAIT falls.
- MEM_WRITE  input  1  block write request, same hold rule.
- MEM_ADDRESS  input  ADDR_WIDTH  block address.
- MEM_WRITE_DATA  input  128  write block; word0 = [31:0].
- MEM_READ_DATA  output  128  registered read block.
- MEM_BUSY_WAIT  output  1  registered; high while an access is in progress.
- MEM_ERROR  output  1  sticky protocol/range error flag.

Behaviour:
- Reset (RESET==0 at an edge): state IDLE; MEM_BUSY_WAIT=0, MEM_READ_DATA=0, MEM_ERROR=0, latency counter=0.
- Reset mid-access aborts the access: a pending write is not committed and no read data is produced.
- Array contents are not reset. Simulation init is all-zero; benches must not rely on that.
- States: IDLE, BUSY, DONE.
- IDLE: at an edge with MEM_READ|MEM_WRITE=1:
  - latch address, op and write data;
  - counter<=LATENCY-1, MEM_BUSY_WAIT<=1, go to BUSY.
- BUSY: MEM_* inputs are ignored; latched values are used.
  - Each edge with counter!=0 decrements the counter.
  - At the edge with counter==0, the access is performed:
    - write: array[addr]<=latched data;
    - read: MEM_READ_DATA<=array[addr].
  - Same edge: MEM_BUSY_WAIT<=0, go to DONE.
  - Net effect: MEM_BUSY_WAIT is high for exactly LATENCY cycles, starting the cycle after the request is sampled.
- DONE: one cycle in which requests are ignored, so the controller can drop its request after seeing MEM_BUSY_WAIT low. Next edge goes to IDLE unconditionally.
- Request-to-data latency: read data is valid from the first cycle MEM_BUSY_WAIT is low after the access. It is held unchanged until the next read completes or reset occurs.
- Writes leave MEM_READ_DATA unchanged.
- MEM_READ and MEM_WRITE both high when sampled in IDLE:
  - treated as a write;
  - MEM_ERROR<=1.
- MEM_ADDRESS >= DEPTH:
  - the access still runs the full LATENCY handshake;
  - a read returns 128'h0;
  - a write is dropped;
  - MEM_ERROR<=1.
- MEM_ERROR clears only on reset.
- Back-to-back requests: a request still held during DONE is not re-accepted. A new request is accepted at the earliest in IDLE, so there are at least 2 idle edges between accesses.
- LATENCY=1: MEM_BUSY_WAIT is high for one cycle; the access happens at the first BUSY edge.

Test Plan:
- Write addr 0x05, data 128'hDDDD_CCCC_BBBB_AAAA_..., then read 0x05 -> MEM_BUSY_WAIT high exactly 4 cycles per access; read returns the identical 128-bit block; MEM_ERROR=0.
- Read request held, with MEM_ADDRESS changed to 0x06 during BUSY -> data returned is from 0x05 (latched address); 0x06 is unchanged.
- MEM_READ=MEM_WRITE=1 at addr 0x10 with data 128'h1 -> block 0x10 becomes 128'h1; MEM_ERROR=1 and stays 1 through later good accesses.
- Read addr 300 with DEPTH=256 -> full 4-cycle busy, then MEM_READ_DATA=0 and MEM_ERROR=1. Write addr 300 -> no block 0..255 is modified.
- Write to 0x20 with RESET driven low during the 2nd busy cycle -> next cycle MEM_BUSY_WAIT=0 and MEM_READ_DATA=0; a later read of 0x20 returns the prior contents, not the aborted data.
- LATENCY=1 build: request held high continuously -> busy pattern 1,0,0 repeating (busy, DONE, IDLE); each access is performed exactly once.
